// File: rtl/btn_debouncer.sv
// btn_debouncer: push-button debouncer sampled by a periodic tick strobe.
// Raw input -> 2-flop synchroniser -> SAMPLES-deep tick-sampled shift register
// -> two-state hysteresis FSM producing a clean level plus press/release pulses.
// Optional long-press detection is compiled in with `define DEBOUNCE_LONGPRESS_EN;
// without it o_long is tied low and no counter logic exists.
module btn_debouncer #(
    parameter int SAMPLES    = 8,
    parameter int LONG_TICKS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_btn,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    // Elaboration-time parameter range checks
    if (SAMPLES < 2 || SAMPLES > 32) begin : g_bad_samples
        $error("btn_debouncer: SAMPLES must be in 2..32");
    end
    if (LONG_TICKS < 1) begin : g_bad_long
        $error("btn_debouncer: LONG_TICKS must be >= 1");
    end

    logic               sync1_q;
    logic               sync2_q;
    logic [SAMPLES-1:0] sr_q;
    logic [SAMPLES-1:0] nxt;
    state_t             state_q;
    state_t             state_d;
    logic               btn_q;
    logic               rise_q;
    logic               rise_d;
    logic               fall_q;
    logic               fall_d;

    // Two-flop synchroniser bringing the asynchronous button into clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    // Sample window including the sample taken on the current edge
    always_comb begin
        nxt = {sr_q[SAMPLES-2:0], sync2_q};
    end

    // Shift in one synchronised sample per tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (i_tick) begin
            sr_q <= nxt;
        end
    end

    // Next-state and pulse decode: change state only on a unanimous window
    always_comb begin
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            RELEASED: begin
                if (i_tick && (&nxt)) begin
                    state_d = PRESSED;
                    rise_d  = 1'b1;
                end
            end
            PRESSED: begin
                if (i_tick && !(|nxt)) begin
                    state_d = RELEASED;
                    fall_d  = 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    // State register plus registered level and edge pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RELEASED;
            btn_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= (state_d == PRESSED);
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_btn  = btn_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int CW = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_TICKS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          long_q;
    logic          long_d;

    // Saturating hold counter; the release edge wins over a final increment
    always_comb begin
        cnt_d  = cnt_q;
        long_d = 1'b0;
        if (state_q == RELEASED || fall_d) begin
            cnt_d = '0;
        end else if (i_tick && cnt_q != LONG_MAX) begin
            cnt_d  = cnt_q + 1'b1;
            long_d = (cnt_q == LONG_MAX - 1'b1);
        end
    end

    // Long-press counter and pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            long_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            long_q <= long_d;
        end
    end

    assign o_long = long_q;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: directed stimulus with an event scoreboard.
// The driver pushes expected pulses (kind, tick number) into a queue; a
// monitor pops and compares whenever the DUT raises o_rise/o_fall/o_long.
module tb_btn_debouncer;

    localparam int SAMPLES    = 4;
    localparam int LONG_TICKS = 5;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_LONG = 2;

    typedef struct {
        int kind;
        int tick;
    } ev_t;

    logic clk;
    logic rst;
    logic i_tick;
    logic i_btn;
    logic o_btn;
    logic o_rise;
    logic o_fall;
    logic o_long;

    ev_t   exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    tick_cnt = 0;
    int    phase    = 0;
    string names[3] = '{"rise", "fall", "long"};

    btn_debouncer #(
        .SAMPLES   (SAMPLES),
        .LONG_TICKS(LONG_TICKS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_tick(i_tick),
        .i_btn (i_btn),
        .o_btn (o_btn),
        .o_rise(o_rise),
        .o_fall(o_fall),
        .o_long(o_long)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, req, tick_cnt);
        end
    endtask

    task automatic expect_ev(input int kind, input int tick);
        ev_t e;
        e.kind = kind;
        e.tick = tick;
        exp_q.push_back(e);
    endtask

    task automatic expect_long(input int tick);
        if (LONG_EN) expect_ev(K_LONG, tick);
    endtask

    task automatic seen(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_%s: got pulse at tick %0d expected none", names[kind], tick_cnt);
        end else begin
            e = exp_q.pop_front();
            check({names[kind], "_kind"}, kind, e.kind);
            check({names[kind], "_tick"}, tick_cnt, e.tick);
            check({names[kind], "_level"}, int'(o_btn), (kind == K_FALL) ? 0 : 1);
        end
    endtask

    // Monitor: sample away from the active edge and score every pulse
    always @(negedge clk) begin
        if (rst) begin
            if (o_rise) seen(K_RISE);
            if (o_fall) seen(K_FALL);
            if (o_long) seen(K_LONG);
        end
    end

    // One clock with a tick on every third cycle
    task automatic cyc1();
        i_tick = (phase == 2);
        phase  = (phase + 1) % 3;
        @(posedge clk);
        if (i_tick) tick_cnt++;
        #1;
    endtask

    // Advance n tick edges; returns right after a tick edge
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cyc1();
            while (phase != 0) cyc1();
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_o_btn"},  int'(o_btn),  0);
        check({tag, "_o_rise"}, int'(o_rise), 0);
        check({tag, "_o_fall"}, int'(o_fall), 0);
        check({tag, "_o_long"}, int'(o_long), 0);
    endtask

    int t;

    initial begin
        rst    = 1'b0;
        i_btn  = 1'b1;
        i_tick = 1'b0;

        // Reset held with the button pressed
        repeat (5) cyc1();
        check_all_low("reset");
        ticks(1);
        rst = 1'b1;
        t = tick_cnt;
        expect_ev(K_RISE, t + 4);
        expect_long(t + 9);
        ticks(6);
        check("reset_press_level", int'(o_btn), 1);
        i_btn = 1'b0;                 // released at t+6
        expect_ev(K_FALL, t + 10);
        ticks(6);
        check("reset_release_level", int'(o_btn), 0);

        // Clean press for 10 ticks then release
        i_btn = 1'b1;
        t = tick_cnt;
        expect_ev(K_RISE, t + 4);
        expect_long(t + 9);
        ticks(10);
        check("clean_level_high", int'(o_btn), 1);
        i_btn = 1'b0;
        expect_ev(K_FALL, t + 14);
        ticks(6);
        check("clean_level_low", int'(o_btn), 0);

        // Bounce: 2-tick segments starting high, ending low, then settle high
        for (int k = 0; k < 10; k++) begin
            i_btn = (k % 2 == 0);
            ticks(2);
        end
        check("bounce_level", int'(o_btn), 0);
        i_btn = 1'b1;
        t = tick_cnt;
        expect_ev(K_RISE, t + 4);
        ticks(6);
        check("settle_level", int'(o_btn), 1);

        // Reset mid-press: outputs drop at once, no fall pulse
        rst = 1'b0;
        #1;
        check("midreset_o_btn", int'(o_btn), 0);
        i_btn = 1'b0;
        repeat (5) cyc1();
        check_all_low("midreset");
        ticks(1);
        rst = 1'b1;
        ticks(3);
        i_btn = 1'b1;
        t = tick_cnt;
        expect_ev(K_RISE, t + 4);
        expect_long(t + 9);
        ticks(6);
        check("repress_level", int'(o_btn), 1);
        i_btn = 1'b0;
        expect_ev(K_FALL, t + 10);
        ticks(6);

        // Long press: held 12 ticks, twice
        for (int r = 0; r < 2; r++) begin
            i_btn = 1'b1;
            t = tick_cnt;
            expect_ev(K_RISE, t + 4);
            expect_long(t + 9);
            ticks(12);
            check("long_level", int'(o_btn), 1);
            i_btn = 1'b0;
            expect_ev(K_FALL, t + 16);
            ticks(6);
        end

        ticks(3);
        check("pending_events", exp_q.size(), 0);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            $display("FAIL missing_%s: got no pulse expected one at tick %0d", names[e.kind], e.tick);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
